// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the OpenMIPS memory-access stage: aluop codes,
// bus widths, FSM states, byte-lane constants and the op decoder.
package mem_lsu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;
  localparam int REG_W  = 5;
  localparam int OP_W   = 8;

  localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [SEL_W-1:0] SEL_NONE    = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_BYTE0   = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_HI_HALF = 4'b1100;
  localparam logic [SEL_W-1:0] SEL_LO_HALF = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      is_signed;
    acc_size_e size;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [OP_W-1:0] op);
    op_info_t info;
    info = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: SZ_WORD};
    case (op)
      EXE_LB_OP:  info = '{1'b1, 1'b1, 1'b1, SZ_BYTE};
      EXE_LBU_OP: info = '{1'b1, 1'b1, 1'b0, SZ_BYTE};
      EXE_LH_OP:  info = '{1'b1, 1'b1, 1'b1, SZ_HALF};
      EXE_LHU_OP: info = '{1'b1, 1'b1, 1'b0, SZ_HALF};
      EXE_LW_OP:  info = '{1'b1, 1'b1, 1'b0, SZ_WORD};
      EXE_SB_OP:  info = '{1'b1, 1'b0, 1'b0, SZ_BYTE};
      EXE_SH_OP:  info = '{1'b1, 1'b0, 1'b0, SZ_HALF};
      EXE_SW_OP:  info = '{1'b1, 1'b0, 1'b0, SZ_WORD};
      default:    ;
    endcase
    return info;
  endfunction

  function automatic logic is_aligned(input acc_size_e size, input logic [1:0] off);
    case (size)
      SZ_HALF: return ~off[0];
      SZ_WORD: return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: store sel/replication on the way out,
// lane extraction plus sign/zero extension on the way back.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  acc_size_e          size,
  input  logic               is_signed,
  input  logic [1:0]         addr_off,
  input  logic [DATA_W-1:0]  st_data,
  input  logic [DATA_W-1:0]  rdata,
  output logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    sel     = SEL_WORD;
    wdata   = st_data;
    ld_data = rdata;
    ld_byte = rdata[31:24];
    ld_half = addr_off[1] ? rdata[15:0] : rdata[31:16];

    case (addr_off)
      2'd0:    ld_byte = rdata[31:24];
      2'd1:    ld_byte = rdata[23:16];
      2'd2:    ld_byte = rdata[15:8];
      default: ld_byte = rdata[7:0];
    endcase

    case (size)
      SZ_BYTE: begin
        sel     = SEL_BYTE0 >> addr_off;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        sel     = addr_off[1] ? SEL_LO_HALF : SEL_HI_HALF;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{is_signed & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// OpenMIPS MEM stage: zero-latency pass-through for ALU results, stalling
// request/ack data-bus transaction with timeout for loads and stores.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [OP_W-1:0]   mem_aluop,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_reg2,
  output logic [REG_W-1:0]  wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              stallreq,
  output logic              misalign,
  output logic              bus_err,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [SEL_W-1:0]  dbus_sel,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic [DATA_W-1:0] dbus_rdata,
  input  logic              dbus_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  op_info_t          info;
  logic              aligned;
  logic              start;
  logic [SEL_W-1:0]  lane_sel;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] ld_data;

  assign info    = decode_op(mem_aluop);
  assign aligned = is_aligned(info.size, mem_addr[1:0]);
  assign start   = info.is_mem & aligned;

  // Address and op are held by the stall, so one aligner serves both the
  // outgoing store lanes and the later load extraction from rdata_q.
  mem_lane_align u_align (
    .size      (info.size),
    .is_signed (info.is_signed),
    .addr_off  (mem_addr[1:0]),
    .st_data   (mem_reg2),
    .rdata     (rdata_q),
    .sel       (lane_sel),
    .wdata     (lane_wdata),
    .ld_data   (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= SEL_NONE;
      dbus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= ~info.is_load;
            dbus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            dbus_sel   <= lane_sel;
            dbus_wdata <= lane_wdata;
            cnt        <= '0;
            err_q      <= 1'b0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dbus_ack) begin
            rdata_q  <= dbus_rdata;
            dbus_req <= 1'b0;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            dbus_req <= 1'b0;
            err_q    <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writeback and handshake outputs are forced low while reset is held so
  // nothing leaks into MEM/WB even with a memory op presented.
  always_comb begin
    wb_wd    = '0;
    wb_wreg  = 1'b0;
    wb_wdata = '0;
    stallreq = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          wb_wd = mem_wd;
          if (!info.is_mem) begin
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end else if (!aligned) begin
            misalign = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
        ST_BUSY: begin
          wb_wd    = mem_wd;
          stallreq = 1'b1;
        end
        ST_DONE: begin
          wb_wd = mem_wd;
          if (err_q) begin
            bus_err = 1'b1;
          end else if (info.is_load) begin
            wb_wreg  = mem_wreg;
            wb_wdata = ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, loads, stores, misalignment,
// timeout and asynchronous reset in the middle of a bus transaction.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        misalign;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  int checks = 0;
  int errors = 0;

  int          stalls;
  logic [31:0] seen_addr;
  logic [3:0]  seen_sel;
  logic        seen_we;
  logic [31:0] seen_wdata;
  logic        finished;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wd     (mem_wd),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_aluop  (mem_aluop),
    .mem_addr   (mem_addr),
    .mem_reg2   (mem_reg2),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata),
    .stallreq   (stallreq),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_sel   (dbus_sel),
    .dbus_wdata (dbus_wdata),
    .dbus_rdata (dbus_rdata),
    .dbus_ack   (dbus_ack)
  );

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd,
                        input logic wreg, input logic [31:0] wdata);
    mem_aluop = op;
    mem_addr  = addr;
    mem_reg2  = reg2;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
  endtask

  task automatic set_nop();
    set_op(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  // Runs one bus transaction: ack is raised for the ack_at-th BUSY cycle
  // (0 = never). Returns at the negedge of the first non-stalled cycle.
  task automatic run_bus(input int ack_at, input logic [31:0] rd);
    int busy;
    busy = 0;
    stalls = 0;
    finished = 1'b0;
    seen_addr = '0;
    seen_sel = '0;
    seen_we = 1'b0;
    seen_wdata = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dbus_ack = 1'b0;
      if (!stallreq) begin
        finished = 1'b1;
        break;
      end
      stalls++;
      if (dbus_req) begin
        busy++;
        if (busy == 1) begin
          seen_addr  = dbus_addr;
          seen_sel   = dbus_sel;
          seen_we    = dbus_we;
          seen_wdata = dbus_wdata;
        end
        if (busy == ack_at) begin
          dbus_ack   = 1'b1;
          dbus_rdata = rd;
        end
      end
    end
  endtask

  task automatic finish_op();
    @(posedge clk);
    #1;
    set_nop();
    dbus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    set_op(EXE_OR_OP, 32'h104, 32'h55, 5'd7, 1'b1, 32'hCAFE);
    @(negedge clk);
    checks++;
    if ({wb_wd, wb_wreg, wb_wdata} !== 38'h0) begin
      errors++;
      $display("FAIL reset_wb got wd=%0h wreg=%0b wdata=%h want 0", wb_wd, wb_wreg, wb_wdata);
    end
    checks++;
    if ({stallreq, misalign, bus_err, dbus_req, dbus_we, dbus_sel} !== 9'h0
        || dbus_addr !== 32'h0 || dbus_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got stall=%0b req=%0b sel=%b addr=%h wdata=%h want 0",
               stallreq, dbus_req, dbus_sel, dbus_addr, dbus_wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_nop();
  endtask

  task automatic test_nonmem();
    set_op(EXE_OR_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
    dbus_ack = 1'b1;
    #1;
    checks++;
    if (wb_wd !== 5'd5 || wb_wreg !== 1'b1 || wb_wdata !== 32'h1234 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL nonmem_pass got wd=%0d wreg=%0b wdata=%h stall=%0b want 5 1 00001234 0",
               wb_wd, wb_wreg, wb_wdata, stallreq);
    end
    @(posedge clk);
    #1;
    dbus_ack = 1'b0;
    checks++;
    if (dbus_req !== 1'b0 || wb_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL nonmem_noreq got req=%0b wdata=%h want 0 00001234", dbus_req, wb_wdata);
    end
    set_nop();
  endtask

  task automatic test_lw();
    set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd3, 1'b1, 32'h100);
    run_bus(4, 32'hDEADBEEF);
    checks++;
    if (!finished || stalls != 5) begin
      errors++;
      $display("FAIL lw_stall got %0d cycles (finished=%0b) want 5", stalls, finished);
    end
    checks++;
    if (seen_addr !== 32'h100 || seen_sel !== 4'b1111 || seen_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus got addr=%h sel=%b we=%0b want 00000100 1111 0", seen_addr, seen_sel, seen_we);
    end
    checks++;
    if (wb_wdata !== 32'hDEADBEEF || wb_wreg !== 1'b1 || wb_wd !== 5'd3) begin
      errors++;
      $display("FAIL lw_wb got wdata=%h wreg=%0b wd=%0d want deadbeef 1 3", wb_wdata, wb_wreg, wb_wd);
    end
    finish_op();
  endtask

  task automatic test_byte_half_loads();
    set_op(EXE_LB_OP, 32'h101, 32'h0, 5'd4, 1'b1, 32'h101);
    run_bus(1, 32'h11F22233);
    checks++;
    if (!finished || stalls != 2 || seen_sel !== 4'b0100 || seen_addr !== 32'h100) begin
      errors++;
      $display("FAIL lb_bus got stalls=%0d sel=%b addr=%h want 2 0100 00000100", stalls, seen_sel, seen_addr);
    end
    checks++;
    if (wb_wdata !== 32'hFFFFFFF2 || wb_wreg !== 1'b1) begin
      errors++;
      $display("FAIL lb_sext got %h wreg=%0b want fffffff2 1", wb_wdata, wb_wreg);
    end
    finish_op();

    set_op(EXE_LBU_OP, 32'h101, 32'h0, 5'd4, 1'b1, 32'h101);
    run_bus(1, 32'h11F22233);
    checks++;
    if (wb_wdata !== 32'h000000F2) begin
      errors++;
      $display("FAIL lbu_zext got %h want 000000f2", wb_wdata);
    end
    finish_op();

    set_op(EXE_LH_OP, 32'h102, 32'h0, 5'd6, 1'b1, 32'h102);
    run_bus(2, 32'h11F28233);
    checks++;
    if (seen_sel !== 4'b0011 || wb_wdata !== 32'hFFFF8233) begin
      errors++;
      $display("FAIL lh_lo got sel=%b data=%h want 0011 ffff8233", seen_sel, wb_wdata);
    end
    finish_op();

    set_op(EXE_LHU_OP, 32'h100, 32'h0, 5'd6, 1'b1, 32'h100);
    run_bus(1, 32'h91F28233);
    checks++;
    if (seen_sel !== 4'b1100 || wb_wdata !== 32'h000091F2) begin
      errors++;
      $display("FAIL lhu_hi got sel=%b data=%h want 1100 000091f2", seen_sel, wb_wdata);
    end
    finish_op();
  endtask

  task automatic test_stores();
    set_op(EXE_SH_OP, 32'h202, 32'h0000ABCD, 5'd0, 1'b0, 32'h202);
    run_bus(2, 32'h0);
    checks++;
    if (seen_we !== 1'b1 || seen_addr !== 32'h200 || seen_sel !== 4'b0011 || seen_wdata !== 32'hABCDABCD) begin
      errors++;
      $display("FAIL sh_bus got we=%0b addr=%h sel=%b wdata=%h want 1 00000200 0011 abcdabcd",
               seen_we, seen_addr, seen_sel, seen_wdata);
    end
    checks++;
    if (!finished || wb_wreg !== 1'b0) begin
      errors++;
      $display("FAIL sh_done got wreg=%0b finished=%0b want 0 1", wb_wreg, finished);
    end
    finish_op();

    set_op(EXE_SB_OP, 32'h203, 32'h1234565A, 5'd0, 1'b0, 32'h203);
    run_bus(1, 32'h0);
    checks++;
    if (seen_sel !== 4'b0001 || seen_wdata !== 32'h5A5A5A5A || seen_we !== 1'b1) begin
      errors++;
      $display("FAIL sb_bus got sel=%b wdata=%h we=%0b want 0001 5a5a5a5a 1", seen_sel, seen_wdata, seen_we);
    end
    finish_op();
  endtask

  task automatic test_misalign();
    set_op(EXE_LW_OP, 32'h102, 32'h0, 5'd2, 1'b1, 32'h102);
    #1;
    checks++;
    if (misalign !== 1'b1 || wb_wreg !== 1'b0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL lw_misalign got mis=%0b wreg=%0b stall=%0b want 1 0 0", misalign, wb_wreg, stallreq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign_noreq got req=%0b want 0", dbus_req);
    end
    set_op(EXE_LH_OP, 32'h101, 32'h0, 5'd2, 1'b1, 32'h101);
    #1;
    checks++;
    if (misalign !== 1'b1 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL lh_misalign got mis=%0b stall=%0b want 1 0", misalign, stallreq);
    end
    set_nop();
    #1;
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear got %0b want 0", misalign);
    end
  endtask

  task automatic test_timeout();
    @(posedge clk);
    #1;
    set_op(EXE_LW_OP, 32'h300, 32'h0, 5'd9, 1'b1, 32'h300);
    run_bus(0, 32'h0);
    checks++;
    if (!finished || stalls != 5) begin
      errors++;
      $display("FAIL timeout_stall got %0d cycles (finished=%0b) want 5", stalls, finished);
    end
    checks++;
    if (bus_err !== 1'b1 || wb_wreg !== 1'b0 || wb_wdata !== 32'h0 || dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done got err=%0b wreg=%0b wdata=%h req=%0b want 1 0 0 0",
               bus_err, wb_wreg, wb_wdata, dbus_req);
    end
    finish_op();
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got err=%0b stall=%0b want 0 0", bus_err, stallreq);
    end
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk);
    #1;
    set_op(EXE_SW_OP, 32'h400, 32'h87654321, 5'd1, 1'b0, 32'h400);
    @(posedge clk);
    #1;
    checks++;
    if (dbus_req !== 1'b1 || stallreq !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy got req=%0b stall=%0b want 1 1", dbus_req, stallreq);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({dbus_req, dbus_we, dbus_sel, stallreq, misalign, bus_err, wb_wreg} !== 10'h0
        || dbus_addr !== 32'h0 || dbus_wdata !== 32'h0 || wb_wdata !== 32'h0 || wb_wd !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_async got req=%0b sel=%b addr=%h wdata=%h stall=%0b wd=%0d want all 0",
               dbus_req, dbus_sel, dbus_addr, dbus_wdata, stallreq, wb_wd);
    end
    @(posedge clk);
    #1;
    set_op(EXE_OR_OP, 32'h0, 32'h0, 5'd8, 1'b1, 32'h00C0FFEE);
    dbus_ack = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    dbus_ack = 1'b0;
    checks++;
    if (stallreq !== 1'b0 || bus_err !== 1'b0 || wb_wreg !== 1'b1 || wb_wdata !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL rstmid_idle got stall=%0b err=%0b wreg=%0b wdata=%h want 0 0 1 00c0ffee",
               stallreq, bus_err, wb_wreg, wb_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dbus_req !== 1'b0 || wb_wdata !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL rstmid_after got req=%0b wdata=%h want 0 00c0ffee", dbus_req, wb_wdata);
    end
    set_nop();
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_lw();
    test_byte_half_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
